fe_stage_btb: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the decode stage and drives the FE latch that decode consumes.
- Holds the fetch PC and presents a combinational read address to instruction memory.
- Captures the fetched word plus PC, PC+4, instruction count and branch-prediction info into the FE latch.
- Honours the decode stall, squashes on AGEX branch redirect, and predicts next-PC with a direct-mapped BTB that has 2-bit saturating counters.

---
 rtl/fe_stage_btb.sv | 165 ++++++++++++++++
 tb/tb_fe_stage_btb.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fe_stage_btb.sv
// fe_stage_btb: fetch stage driving the FE latch, with a direct-mapped 2-bit-counter BTB
module fe_stage_btb #(
  parameter int               DBITS        = 32,
  parameter int               BTB_IDX_BITS = 4,
  parameter logic [DBITS-1:0] START_PC     = '0,
  parameter logic [3:0]       CANARY       = 4'hF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_de_i,
  input  logic             br_redirect_i,
  input  logic [DBITS-1:0] br_target_i,
  input  logic             btb_upd_i,
  input  logic [DBITS-1:0] btb_upd_pc_i,
  input  logic [DBITS-1:0] btb_upd_target_i,
  input  logic             btb_upd_taken_i,
  output logic [DBITS-1:0] imem_addr_o,
  input  logic [31:0]      imem_rdata_i,
  output logic             fe_valid_o,
  output logic [31:0]      fe_inst_o,
  output logic [DBITS-1:0] fe_pc_o,
  output logic [DBITS-1:0] fe_pcplus_o,
  output logic [DBITS-1:0] fe_inst_count_o,
  output logic             fe_pred_taken_o,
  output logic [DBITS-1:0] fe_pred_target_o,
  output logic [3:0]       fe_canary_o
);
  localparam int N  = 1 << BTB_IDX_BITS;
  localparam int TW = DBITS - BTB_IDX_BITS - 2;

  logic [DBITS-1:0] pc_q, pc_d, icount_q, icount_d;
  logic             fe_valid_q, fe_valid_d, fe_pred_taken_q, fe_pred_taken_d;
  logic [31:0]      fe_inst_q, fe_inst_d;
  logic [DBITS-1:0] fe_pc_q, fe_pc_d, fe_pcplus_q, fe_pcplus_d;
  logic [DBITS-1:0] fe_inst_count_q, fe_inst_count_d, fe_pred_target_q, fe_pred_target_d;
  logic [3:0]       fe_canary_q, fe_canary_d;

  logic             btb_v_q   [N];
  logic             btb_v_d   [N];
  logic [TW-1:0]    btb_tag_q [N];
  logic [TW-1:0]    btb_tag_d [N];
  logic [DBITS-1:0] btb_tgt_q [N];
  logic [DBITS-1:0] btb_tgt_d [N];
  logic [1:0]       btb_ctr_q [N];
  logic [1:0]       btb_ctr_d [N];

  logic [BTB_IDX_BITS-1:0] l_idx, u_idx;
  logic [TW-1:0]           l_tag, u_tag;
  logic                    hit, u_hit, pred_taken, unused_ok;
  logic [DBITS-1:0]        pc_plus4, pred_next;
  logic [1:0]              u_ctr;

  assign l_idx     = pc_q[BTB_IDX_BITS+1:2];
  assign l_tag     = pc_q[DBITS-1:BTB_IDX_BITS+2];
  assign u_idx     = btb_upd_pc_i[BTB_IDX_BITS+1:2];
  assign u_tag     = btb_upd_pc_i[DBITS-1:BTB_IDX_BITS+2];
  assign unused_ok = ^btb_upd_pc_i[1:0];
  assign hit       = btb_v_q[l_idx] && btb_tag_q[l_idx] == l_tag;
  assign u_hit     = btb_v_q[u_idx] && btb_tag_q[u_idx] == u_tag;
  assign u_ctr     = btb_ctr_q[u_idx];
  assign pred_taken = hit && btb_ctr_q[l_idx][1];
  assign pc_plus4  = pc_q + DBITS'(4);
  assign pred_next = pred_taken ? btb_tgt_q[l_idx] : pc_plus4;

  assign imem_addr_o      = pc_q;
  assign fe_valid_o       = fe_valid_q;
  assign fe_inst_o        = fe_inst_q;
  assign fe_pc_o          = fe_pc_q;
  assign fe_pcplus_o      = fe_pcplus_q;
  assign fe_inst_count_o  = fe_inst_count_q;
  assign fe_pred_taken_o  = fe_pred_taken_q;
  assign fe_pred_target_o = fe_pred_target_q;
  assign fe_canary_o      = fe_canary_q;

  // next PC / FE latch: redirect squashes and wins over stall, stall holds, else advance
  always_comb begin
    pc_d             = pc_q;
    icount_d         = icount_q;
    fe_valid_d       = fe_valid_q;
    fe_inst_d        = fe_inst_q;
    fe_pc_d          = fe_pc_q;
    fe_pcplus_d      = fe_pcplus_q;
    fe_inst_count_d  = fe_inst_count_q;
    fe_pred_taken_d  = fe_pred_taken_q;
    fe_pred_target_d = fe_pred_target_q;
    fe_canary_d      = fe_canary_q;
    if (br_redirect_i) begin
      pc_d             = br_target_i;
      fe_valid_d       = 1'b0;
      fe_inst_d        = '0;
      fe_pc_d          = '0;
      fe_pcplus_d      = '0;
      fe_inst_count_d  = '0;
      fe_pred_taken_d  = 1'b0;
      fe_pred_target_d = '0;
      fe_canary_d      = '0;
    end else if (!stall_de_i) begin
      pc_d             = pred_next;
      icount_d         = icount_q + DBITS'(1);
      fe_valid_d       = 1'b1;
      fe_inst_d        = imem_rdata_i;
      fe_pc_d          = pc_q;
      fe_pcplus_d      = pc_plus4;
      fe_inst_count_d  = icount_q;
      fe_pred_taken_d  = pred_taken;
      fe_pred_target_d = pred_next;
      fe_canary_d      = CANARY;
    end
  end

  // BTB training: hits move the counter, taken misses allocate, not-taken misses are ignored
  always_comb begin
    btb_v_d   = btb_v_q;
    btb_tag_d = btb_tag_q;
    btb_tgt_d = btb_tgt_q;
    btb_ctr_d = btb_ctr_q;
    if (btb_upd_i && u_hit) begin
      btb_ctr_d[u_idx] = btb_upd_taken_i ? (u_ctr == 2'b11 ? u_ctr : u_ctr + 2'd1)
                                         : (u_ctr == 2'b00 ? u_ctr : u_ctr - 2'd1);
      btb_tgt_d[u_idx] = btb_upd_taken_i ? btb_upd_target_i : btb_tgt_q[u_idx];
    end else if (btb_upd_i && btb_upd_taken_i) begin
      btb_v_d[u_idx]   = 1'b1;
      btb_tag_d[u_idx] = u_tag;
      btb_tgt_d[u_idx] = btb_upd_target_i;
      btb_ctr_d[u_idx] = 2'b10;
    end
  end

  // state registers; reset wipes the PC, count, FE latch and every BTB entry
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q             <= START_PC;
      icount_q         <= '0;
      fe_valid_q       <= 1'b0;
      fe_inst_q        <= '0;
      fe_pc_q          <= '0;
      fe_pcplus_q      <= '0;
      fe_inst_count_q  <= '0;
      fe_pred_taken_q  <= 1'b0;
      fe_pred_target_q <= '0;
      fe_canary_q      <= '0;
      for (int i = 0; i < N; i++) begin
        btb_v_q[i]   <= 1'b0;
        btb_tag_q[i] <= '0;
        btb_tgt_q[i] <= '0;
        btb_ctr_q[i] <= '0;
      end
    end else begin
      pc_q             <= pc_d;
      icount_q         <= icount_d;
      fe_valid_q       <= fe_valid_d;
      fe_inst_q        <= fe_inst_d;
      fe_pc_q          <= fe_pc_d;
      fe_pcplus_q      <= fe_pcplus_d;
      fe_inst_count_q  <= fe_inst_count_d;
      fe_pred_taken_q  <= fe_pred_taken_d;
      fe_pred_target_q <= fe_pred_target_d;
      fe_canary_q      <= fe_canary_d;
      btb_v_q          <= btb_v_d;
      btb_tag_q        <= btb_tag_d;
      btb_tgt_q        <= btb_tgt_d;
      btb_ctr_q        <= btb_ctr_d;
    end
  end
endmodule

// File: tb/tb_fe_stage_btb.sv
// tb_fe_stage_btb: directed and random fetch/BTB traffic checked against a behavioural model
module tb_fe_stage_btb;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_de_i = 1'b0, br_redirect_i = 1'b0, btb_upd_i = 1'b0, btb_upd_taken_i = 1'b0;
  logic [31:0] br_target_i = '0, btb_upd_pc_i = '0, btb_upd_target_i = '0;
  logic [31:0] imem_addr_o, imem_rdata_i, fe_inst_o, fe_pc_o, fe_pcplus_o, fe_inst_count_o, fe_pred_target_o;
  logic        fe_valid_o, fe_pred_taken_o;
  logic [3:0]  fe_canary_o;
  logic [31:0] w_addr, w_inst, w_pc, w_pcplus, w_count, w_ptgt;
  logic        w_valid, w_pt;
  logic [3:0]  w_can;
  logic        imem_mode = 1'b0;
  int          n_assert = 0, n_fail = 0;

  logic [31:0] m_pc, m_ic, m_inst, m_fpc, m_fpp, m_fic, m_ptg;
  logic        m_v, m_pt;
  logic [3:0]  m_can;
  logic        bv [16];
  logic [31:0] btag [16], btgt [16];
  int          bctr [16];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return imem_mode ? ((a * 32'h9E3779B1) ^ 32'h13) : 32'h13;
  endfunction

  always_comb imem_rdata_i = mem(imem_addr_o);

  fe_stage_btb dut (
    .clk(clk), .reset(reset), .stall_de_i(stall_de_i), .br_redirect_i(br_redirect_i),
    .br_target_i(br_target_i), .btb_upd_i(btb_upd_i), .btb_upd_pc_i(btb_upd_pc_i),
    .btb_upd_target_i(btb_upd_target_i), .btb_upd_taken_i(btb_upd_taken_i),
    .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i), .fe_valid_o(fe_valid_o),
    .fe_inst_o(fe_inst_o), .fe_pc_o(fe_pc_o), .fe_pcplus_o(fe_pcplus_o),
    .fe_inst_count_o(fe_inst_count_o), .fe_pred_taken_o(fe_pred_taken_o),
    .fe_pred_target_o(fe_pred_target_o), .fe_canary_o(fe_canary_o)
  );

  fe_stage_btb #(.START_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset), .stall_de_i(1'b0), .br_redirect_i(1'b0),
    .br_target_i(32'h0), .btb_upd_i(1'b0), .btb_upd_pc_i(32'h0),
    .btb_upd_target_i(32'h0), .btb_upd_taken_i(1'b0),
    .imem_addr_o(w_addr), .imem_rdata_i(32'h13), .fe_valid_o(w_valid),
    .fe_inst_o(w_inst), .fe_pc_o(w_pc), .fe_pcplus_o(w_pcplus),
    .fe_inst_count_o(w_count), .fe_pred_taken_o(w_pt),
    .fe_pred_target_o(w_ptgt), .fe_canary_o(w_can)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("valid", {31'b0, fe_valid_o}, {31'b0, m_v});
    chk("inst", fe_inst_o, m_inst);
    chk("pc", fe_pc_o, m_fpc);
    chk("pcplus", fe_pcplus_o, m_fpp);
    chk("count", fe_inst_count_o, m_fic);
    chk("pred_taken", {31'b0, fe_pred_taken_o}, {31'b0, m_pt});
    chk("pred_target", fe_pred_target_o, m_ptg);
    chk("canary", {28'b0, fe_canary_o}, {28'b0, m_can});
    chk("imem_addr", imem_addr_o, m_pc);
  endtask

  task automatic clear_fe();
    m_v = 0; m_inst = 0; m_fpc = 0; m_fpp = 0; m_fic = 0; m_pt = 0; m_ptg = 0; m_can = 0;
  endtask

  task automatic model_step(input logic r, s, rd, input logic [31:0] tg,
                            input logic u, input logic [31:0] up, ut, input logic uk);
    int i, j;
    logic hit, pt;
    logic [31:0] pn;
    if (r) begin
      m_pc = 0; m_ic = 0; clear_fe();
      for (int k = 0; k < 16; k++) begin bv[k] = 0; bctr[k] = 0; btag[k] = 0; btgt[k] = 0; end
      return;
    end
    i   = int'((m_pc >> 2) & 32'd15);
    hit = bv[i] && btag[i] == (m_pc >> 6);
    pt  = hit && bctr[i] >= 2;
    pn  = pt ? btgt[i] : m_pc + 32'd4;
    if (rd) begin
      m_pc = tg; clear_fe();
    end else if (!s) begin
      m_v = 1; m_inst = mem(m_pc); m_fpc = m_pc; m_fpp = m_pc + 32'd4; m_fic = m_ic;
      m_pt = pt; m_ptg = pn; m_can = 4'hF; m_pc = pn; m_ic = m_ic + 32'd1;
    end
    if (u) begin
      j = int'((up >> 2) & 32'd15);
      if (bv[j] && btag[j] == (up >> 6)) begin
        if (uk) begin
          if (bctr[j] < 3) bctr[j]++;
          btgt[j] = ut;
        end else if (bctr[j] > 0) bctr[j]--;
      end else if (uk) begin
        bv[j] = 1; btag[j] = up >> 6; btgt[j] = ut; bctr[j] = 2;
      end
    end
  endtask

  task automatic tick(input logic r, s, rd, input logic [31:0] tg,
                      input logic u, input logic [31:0] up, ut, input logic uk);
    reset = r; stall_de_i = s; br_redirect_i = rd; br_target_i = tg;
    btb_upd_i = u; btb_upd_pc_i = up; btb_upd_target_i = ut; btb_upd_taken_i = uk;
    @(posedge clk);
    model_step(r, s, rd, tg, u, up, ut, uk);
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_valid", {31'b0, fe_valid_o}, 32'd0);
    chk("rst_addr", imem_addr_o, 32'd0);
    run(1);
    chk("first_pc", fe_pc_o, 32'h0);
    chk("first_inst", fe_inst_o, 32'h13);
    chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap_pcplus", w_pcplus, 32'h0);
    run(1);
    chk("pre_stall_addr", imem_addr_o, 32'h8);
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 0, 0, 0, 0, 0, 0);
      chk("stall_addr", imem_addr_o, 32'h8);
      chk("stall_pc", fe_pc_o, 32'h4);
      chk("stall_count", fe_inst_count_o, 32'd1);
    end
    run(1);
    chk("resume_pc", fe_pc_o, 32'h8);
    chk("resume_count", fe_inst_count_o, 32'd2);
    run(1);
    chk("pc_c", fe_pc_o, 32'hC);
    chk("canary_f", {28'b0, fe_canary_o}, 32'hF);
    tick(0, 1, 1, 32'h100, 0, 0, 0, 0);
    chk("redir_valid", {31'b0, fe_valid_o}, 32'd0);
    chk("redir_pc", fe_pc_o, 32'h0);
    chk("redir_canary", {28'b0, fe_canary_o}, 32'h0);
    chk("redir_addr", imem_addr_o, 32'h100);
    run(1);
    chk("after_redir_pc", fe_pc_o, 32'h100);
    chk("after_redir_count", fe_inst_count_o, 32'd4);
    tick(0, 0, 1, 32'h10, 1, 32'h10, 32'h40, 1);
    run(1);
    chk("btb_pt", {31'b0, fe_pred_taken_o}, 32'd1);
    chk("btb_tgt", fe_pred_target_o, 32'h40);
    run(1);
    chk("btb_follow", fe_pc_o, 32'h40);
    tick(0, 0, 0, 0, 1, 32'h10, 32'h0, 0);
    tick(0, 0, 0, 0, 1, 32'h10, 32'h0, 0);
    tick(0, 0, 1, 32'h10, 0, 0, 0, 0);
    run(1);
    chk("nt_pt", {31'b0, fe_pred_taken_o}, 32'd0);
    chk("nt_tgt", fe_pred_target_o, 32'h14);
    tick(0, 0, 1, 32'h20, 1, 32'h20, 32'h200, 0);
    run(1);
    chk("nt_noalloc", {31'b0, fe_pred_taken_o}, 32'd0);
    tick(0, 0, 0, 0, 1, 32'h10, 32'h40, 1);
    tick(0, 0, 0, 0, 1, 32'h10, 32'h40, 1);
    tick(0, 0, 1, 32'h10, 1, 32'h50, 32'h80, 1);
    run(1);
    chk("alias_pt", {31'b0, fe_pred_taken_o}, 32'd0);
    chk("alias_tgt", fe_pred_target_o, 32'h14);
    tick(0, 0, 1, 32'h30, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 32'h30, 32'h90, 1);
    chk("same_cycle_pt", {31'b0, fe_pred_taken_o}, 32'd0);
    tick(0, 0, 1, 32'h30, 0, 0, 0, 0);
    run(1);
    chk("trained_tgt", fe_pred_target_o, 32'h90);
    tick(1, 1, 1, 32'h300, 0, 0, 0, 0);
    chk("midrst_addr", imem_addr_o, 32'h0);
    chk("midrst_valid", {31'b0, fe_valid_o}, 32'd0);
    tick(0, 0, 1, 32'h30, 0, 0, 0, 0);
    run(1);
    chk("btb_lost", {31'b0, fe_pred_taken_o}, 32'd0);
    imem_mode = 1'b1;
    for (int k = 0; k < 400; k++) begin
      tick($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           32'($urandom_range(0, 127)) * 32'd4, $urandom_range(0, 2) == 0,
           32'($urandom_range(0, 127)) * 32'd4, 32'($urandom_range(0, 127)) * 32'd4,
           1'($urandom_range(0, 1)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
